// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with valid/ready handshakes on both sides.
module rv32_muldiv_unit #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg_lo;
  logic              neg_hi;
  logic [XLEN-1:0]   addend;
  logic [2*XLEN-1:0] acc;

  logic              s1_signed, s2_signed, neg1, neg2;
  logic [XLEN-1:0]   abs1, abs2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_result;

  assign s1_signed = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
  assign s2_signed = funct3 inside {3'b001, 3'b100, 3'b110};
  assign neg1      = s1_signed & src1[XLEN-1];
  assign neg2      = s2_signed & src2[XLEN-1];
  assign abs1      = neg1 ? -src1 : src1;
  assign abs2      = neg2 ? -src2 : src2;
  assign div_zero  = funct3[2] && (src2 == '0);
  assign div_ovf   = (funct3 inside {3'b100, 3'b110}) &&
                     (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = funct3[1] ? src1 : '1;
    else if (div_ovf)
      special_result = funct3[1] ? '0 : src1;
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  assign div_trial = acc[2*XLEN-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, addend};
  assign div_ge    = div_trial >= {1'b0, addend};
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
  assign div_next  = {div_rem, acc[XLEN-2:0], div_ge};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, remv, fix_result;

  assign prod = neg_lo ? -acc : acc;
  assign quo  = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign remv = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_result = '0;
    if (op[2])
      fix_result = op[1] ? remv : quo;
    else if (op == 3'b000)
      fix_result = prod[XLEN-1:0];
    else
      fix_result = prod[2*XLEN-1:XLEN];
  end

  // A divide-by-zero quotient stays all ones regardless of the dividend sign
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      addend    <= '0;
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op     <= funct3;
            neg_lo <= funct3[2] ? ((neg1 ^ neg2) & ~div_zero) : (neg1 ^ neg2);
            neg_hi <= neg1;
            acc    <= {{XLEN{1'b0}}, abs1};
            addend <= abs2;
            cnt    <= '0;
            if (FAST_SPECIAL && (div_zero || div_ovf)) begin
              result <= special_result;
              state  <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1))
            state <= FIX;
        end
        FIX: begin
          result    <= fix_result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Fast special cases arrive here with out_valid still low for one cycle
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state == BUSY) || (state == FIX);

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Directed self-checking bench for rv32_muldiv_unit: instance 0 uses the fast
// special-case path, instance 1 runs every operation through the full iteration.
module tb_rv32_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] src1, src2;
  logic        in_valid  [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [31:0] res_f, res_s;

  int tests_run  = 0;
  int fail_count = 0;

  rv32_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .funct3(funct3), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(res_f), .busy(busy[0])
  );

  rv32_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .funct3(funct3), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(res_s), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] res_of(input int u);
    return (u == 0) ? res_f : res_s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One complete request/response; hold > 0 withholds out_ready for that many DONE cycles
  task automatic applyStimulus(input int u, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res,
                               input int exp_lat, input int hold, input string tag);
    int lat, busy_cnt, ready_hi, bad;
    logic [31:0] held;
    checkOutput({tag, "_ready"}, 64'(in_ready[u]), 64'd1);
    funct3 = f3; src1 = a; src2 = b;
    in_valid[u] = 1'b1; out_ready[u] = (hold == 0);
    @(posedge clk); #1;
    in_valid[u] = 1'b0; src1 = ~a; src2 = ~b;
    busy_cnt = int'(busy[u]); ready_hi = int'(in_ready[u]); lat = 0;
    while (!out_valid[u] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      busy_cnt += int'(busy[u]);
      ready_hi += int'(in_ready[u]);
    end
    checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_res"}, 64'(res_of(u)), 64'(exp_res));
    checkOutput({tag, "_busy"}, 64'(busy_cnt), (exp_lat == 1) ? 64'd0 : 64'd33);
    checkOutput({tag, "_rdylow"}, 64'(ready_hi), 64'd0);
    if (hold > 0) begin
      held = res_of(u); bad = 0;
      funct3 = 3'b000; src1 = 32'd9; src2 = 32'd9;
      for (int i = 0; i < hold; i++) begin
        in_valid[u] = 1'b1;
        @(posedge clk); #1;
        if (!out_valid[u] || res_of(u) !== held || in_ready[u]) bad++;
      end
      checkOutput({tag, "_hold"}, 64'(bad), 64'd0);
      in_valid[u] = 1'b0; out_ready[u] = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput({tag, "_ovdrop"}, 64'(out_valid[u]), 64'd0);
    checkOutput({tag, "_rdyback"}, 64'(in_ready[u]), 64'd1);
    out_ready[u] = 1'b0;
    if (hold > 0) begin
      @(posedge clk); #1;
      checkOutput({tag, "_noaccept"}, 64'(busy[u]), 64'd0);
    end
  endtask

  int rises;
  logic ov_prev;

  initial begin
    rst_n = 1'b0; flush = 1'b0; funct3 = '0; src1 = '0; src2 = '0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ov", 64'(out_valid[0]), 64'd0);
    checkOutput("rst_busy", 64'(busy[0]), 64'd0);
    checkOutput("rst_res", 64'(res_f), 64'd0);
    checkOutput("rst_rdy", 64'(in_ready[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rel_rdy", 64'(in_ready[0]), 64'd1);

    applyStimulus(0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0, "mul");
    applyStimulus(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0, "mulh");
    applyStimulus(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, "mulhu");
    applyStimulus(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0, "mulhsu");
    applyStimulus(0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0, "div");
    applyStimulus(0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0, "rem");
    applyStimulus(0, 3'b101, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, 33, 0, "divu");
    applyStimulus(0, 3'b111, 32'd100,      32'd7,        32'd2,        33, 0, "remu");

    applyStimulus(0, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, "f_div0");
    applyStimulus(0, 3'b111, 32'd5,        32'd0,        32'd5,        1, 0, "f_remu0");
    applyStimulus(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "f_divov");
    applyStimulus(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0, "f_remov");

    applyStimulus(1, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 33, 0, "s_div0");
    applyStimulus(1, 3'b111, 32'd5,        32'd0,        32'd5,        33, 0, "s_remu0");
    applyStimulus(1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0, "s_divov");
    applyStimulus(1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, 0, "s_remov");
    applyStimulus(1, 3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 33, 0, "s_divneg0");
    applyStimulus(1, 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 33, 0, "s_remneg0");

    applyStimulus(0, 3'b101, 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF, 33, 5, "bp");

    // Flush ten cycles into a divide, with a competing request in the flush cycle
    funct3 = 3'b100; src1 = 32'd1000; src2 = 32'd7; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid[0] = 1'b1; funct3 = 3'b000; src1 = 32'd5; src2 = 32'd6;
    @(posedge clk); #1;
    flush = 1'b0; in_valid[0] = 1'b0;
    checkOutput("fl_ov", 64'(out_valid[0]), 64'd0);
    checkOutput("fl_rdy", 64'(in_ready[0]), 64'd1);
    checkOutput("fl_busy", 64'(busy[0]), 64'd0);
    rises = 0; ov_prev = out_valid[0];
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid[0] && !ov_prev) rises++;
      ov_prev = out_valid[0];
    end
    checkOutput("fl_norise", 64'(rises), 64'd0);
    out_ready[0] = 1'b0;
    applyStimulus(0, 3'b000, 32'd3, 32'd4, 32'd12, 33, 0, "fl_mul");

    // Reset in the middle of a multiply
    funct3 = 3'b000; src1 = 32'd11; src2 = 32'd13; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("mr_ov", 64'(out_valid[0]), 64'd0);
    checkOutput("mr_busy", 64'(busy[0]), 64'd0);
    checkOutput("mr_res", 64'(res_f), 64'd0);
    checkOutput("mr_rdy", 64'(in_ready[0]), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("mr_idle", 64'(in_ready[0]), 64'd1);
    applyStimulus(0, 3'b111, 32'd100, 32'd7, 32'd2, 33, 0, "mr_remu");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
